minv_result_unloader: RTL and testbench
=======================================

# minv_result_unloader

Drains the 256-bit modular-inverse result from the MINV datapath as sixteen 16-bit words over a valid/ready stream, least-significant word first. It is the output-side counterpart of the datapath's 16-bit word loaders: the datapath fills its 256-bit registers one `datain` word per cycle, and this block captures `u` and `minv_flag` when `minv_rdy` rises and hands the words back to the host. It sits between the MINV datapath/controller and the host bus interface.

## Interface
Parameters:
- `WORD_W`, 16: stream word width.
- `NWORDS`, 16: words per result. `WORD_W*NWORDS` must equal 256.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `u`  in  256: result operand from the datapath; sampled only at capture.
- `minv_flag`  in  1: 1 means no inverse exists (u≠1 at test); sampled at capture.
- `minv_rdy`  in  1: datapath done level flag; stays high until the next `minv_en`.
- `dataout`  out  16: current result word.
- `dout_valid`  out  1: `dataout` is valid.
- `dout_ready`  in  1: host accepts the word.
- `dout_last`  out  1: the current word is word NWORDS-1.
- `no_inv`  out  1: captured `minv_flag`, held for the whole frame.
- `busy`  out  1: a frame is pending or in flight.
- `xfer_done`  out  1: one-cycle pulse after the last handshake.
- `overrun`  out  1: one-cycle pulse when a `minv_rdy` rising edge is dropped.

## Operation
- Edge detect: `rdy_d` is `minv_rdy` registered, reset to 0. `rdy_rise = minv_rdy & ~rdy_d`. If `minv_rdy` is already high when reset is released, that counts as a rise on the first clock.
- FSM states:
  - IDLE: `busy=0`, `dout_valid=0`. On `rdy_rise`, load `sreg <= u`, set `no_inv <= minv_flag`, set `cnt <= 0`, and go to SEND.
  - SEND: `dout_valid=1`, `dataout=sreg[15:0]`, `dout_last=(cnt==NWORDS-1)`.
    - Handshake (`dout_valid & dout_ready`) with cnt<NWORDS-1: `sreg <= sreg>>16` with zero fill, `cnt <= cnt+1`.
    - Handshake with cnt==NWORDS-1: go to IDLE, pulse `xfer_done`, clear `dout_last`.
    - No handshake: `dataout`, `dout_last` and `cnt` hold.
- A `rdy_rise` while in SEND does not alter the frame. It pulses `overrun` and is discarded.
- A `rdy_rise` in the same cycle as the final handshake is also an overrun. The block returns to IDLE and does not re-capture.
- `no_inv` holds its value through IDLE until the next capture. The data words are sent regardless of `no_inv`.
- `cnt` is 4 bits wide (log2 NWORDS) and never wraps inside a frame.

## Timing
- Reset values: `dataout=0`, `dout_valid=0`, `dout_last=0`, `no_inv=0`, `busy=0`, `xfer_done=0`, `overrun=0`. FSM is in IDLE, `sreg=0`, `cnt=0`.
- Latency: `rdy_rise` sampled at edge N gives `dout_valid=1` with word 0 from edge N (visible in cycle N+1).
- Throughput: with `dout_ready` held high, one word per cycle, so a frame takes 16 cycles. `xfer_done` is high in the cycle after the 16th handshake, and `busy` is low in that same cycle.
- Stream rule: once `dout_valid` rises, `dataout`, `dout_valid` and `dout_last` stay stable until the handshake. `dout_valid` does not depend combinationally on `dout_ready`.
- All outputs are registered.
- Asserting `rst_n` low mid-frame aborts immediately. Outputs go to their reset values with no `xfer_done`. The next frame needs a fresh `rdy_rise` after reset release.

## Structure
- Shared package `minv_pkg`:
  - FSM state enum {IDLE, SEND}.
  - Constants `MINV_W=256`, `MINV_WORD_W=16`, `MINV_NWORDS=16`.
  - These are reused by the datapath loaders.
- One natural sub-module, `minv_rise_det`: a registered level-to-pulse edge detector with asynchronous active-low reset. Everything else stays in this module.

## Test plan
- Basic frame: u = 256'h000F_000E_…_0001_0000 (word k = k), `minv_flag=0`, `dout_ready=1`, raise `minv_rdy`. Expect words 0x0000…0x000F on 16 consecutive cycles, `dout_last` only with 0x000F, then one `xfer_done` pulse and `no_inv=0`.
- Backpressure: same u, `dout_ready` toggling 1,0,0,1,… Expect word order unchanged, `dataout` stable while not ready, exactly 16 handshakes.
- No inverse: u=256'h5, `minv_flag=1`. Expect word0=0x0005, words 1–15 = 0x0000, `no_inv=1` through the frame and after it.
- Overrun: drop `minv_rdy` and raise it again at word 5, capturing u=0. Expect one `overrun` pulse and the original words 5–15 intact.
- Level flag: hold `minv_rdy` high for 40 cycles. Expect exactly one frame and no second capture.
- Reset mid-frame: assert `rst_n`=0 at word 7. Expect all outputs at 0 immediately, no `xfer_done`. After release with `minv_rdy` still high, expect a new frame to start on the first clock.

Source files
------------

// File: rtl/minv_pkg.sv
// Shared MINV definitions: result geometry and the unloader FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minv_pkg;

    localparam int MINV_W      = 256;
    localparam int MINV_WORD_W = 16;
    localparam int MINV_NWORDS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } minv_state_t;

endpackage

// File: rtl/minv_rise_det.sv
// Level-to-pulse rising-edge detector (registered history bit).
// Latency: rise is combinational from lvl against last cycle's registered lvl.
// Backpressure: none.
//   clk, rst_n : clock, async active-low reset (history clears to 0)
//   lvl        : level input
//   rise       : high while lvl=1 and lvl was 0 at the previous edge
module minv_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic rise
);

    logic lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    // History resets to 0, so a level already high at reset release
    // reads as a rise on the first clock.
    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/minv_result_unloader.sv
// Drains the captured 256-bit MINV result as NWORDS stream words, LS word first.
// Latency: minv_rdy rise sampled at edge N -> word 0 valid from edge N.
// Backpressure: valid/ready; word, valid and last hold until the handshake.
//   u, minv_flag    : result and no-inverse flag, sampled on capture only
//   minv_rdy        : datapath done level; its rising edge starts a frame
//   dataout/dout_*  : output word stream (valid, ready, last)
//   no_inv          : captured minv_flag, held until the next capture
//   busy            : frame in flight
//   xfer_done       : one-cycle pulse after the final handshake
//   overrun         : one-cycle pulse when a minv_rdy rise is discarded
module minv_result_unloader
    import minv_pkg::*;
#(
    parameter int WORD_W = MINV_WORD_W,
    parameter int NWORDS = MINV_NWORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MINV_W-1:0] u,
    input  logic              minv_flag,
    input  logic              minv_rdy,
    output logic [WORD_W-1:0] dataout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              no_inv,
    output logic              busy,
    output logic              xfer_done,
    output logic              overrun
);

    localparam int                CNT_W    = $clog2(NWORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NWORDS - 1);

    minv_state_t       state, state_nxt;
    logic [MINV_W-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              no_inv_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic              xfer_done_nxt;
    logic              overrun_nxt;
    logic              rdy_rise;
    logic              hs;

    minv_rise_det u_rise_det (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (minv_rdy),
        .rise  (rdy_rise)
    );

    assign hs = dout_valid & dout_ready;

    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        no_inv_nxt    = no_inv;
        valid_nxt     = dout_valid;
        last_nxt      = dout_last;
        xfer_done_nxt = 1'b0;
        overrun_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rdy_rise) begin
                    sreg_nxt   = u;
                    no_inv_nxt = minv_flag;
                    cnt_nxt    = '0;
                    valid_nxt  = 1'b1;
                    last_nxt   = (CNT_LAST == '0);
                    state_nxt  = ST_SEND;
                end
            end
            ST_SEND: begin
                // Any new result arriving mid-frame is dropped, including one
                // that coincides with the final handshake.
                overrun_nxt = rdy_rise;
                if (hs) begin
                    // Shift on the final word too so dataout idles at zero.
                    sreg_nxt = sreg >> WORD_W;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt       = '0;
                        valid_nxt     = 1'b0;
                        last_nxt      = 1'b0;
                        xfer_done_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end else begin
                        cnt_nxt  = cnt + CNT_W'(1);
                        last_nxt = ((cnt + CNT_W'(1)) == CNT_LAST);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            no_inv     <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            xfer_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            cnt        <= cnt_nxt;
            no_inv     <= no_inv_nxt;
            dout_valid <= valid_nxt;
            dout_last  <= last_nxt;
            xfer_done  <= xfer_done_nxt;
            overrun    <= overrun_nxt;
        end
    end

    assign dataout = sreg[WORD_W-1:0];
    // Capture enters SEND directly, so "frame in flight" is exactly dout_valid.
    assign busy    = dout_valid;

endmodule

// File: tb/tb_minv_result_unloader.sv
module tb_minv_result_unloader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] u;
    logic         minv_flag;
    logic         minv_rdy;
    logic [15:0]  dataout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         no_inv;
    logic         busy;
    logic         xfer_done;
    logic         overrun;

    always #5 clk = ~clk;

    minv_result_unloader #(.WORD_W(16), .NWORDS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .u          (u),
        .minv_flag  (minv_flag),
        .minv_rdy   (minv_rdy),
        .dataout    (dataout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .no_inv     (no_inv),
        .busy       (busy),
        .xfer_done  (xfer_done),
        .overrun    (overrun)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: frame = captured 256-bit value + word index
    logic         m_active;
    int           m_idx;
    logic [255:0] m_frame;
    logic         m_prev;
    logic         m_noinv;
    logic         m_xfer;
    logic         m_ovr;
    wire          m_rise = minv_rdy & ~m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_idx <= 0; m_frame <= '0; m_prev <= 1'b0;
            m_noinv <= 1'b0; m_xfer <= 1'b0; m_ovr <= 1'b0;
        end else begin
            m_prev <= minv_rdy;
            m_xfer <= 1'b0;
            m_ovr  <= 1'b0;
            if (!m_active) begin
                if (m_rise) begin
                    m_active <= 1'b1; m_idx <= 0; m_frame <= u; m_noinv <= minv_flag;
                end
            end else begin
                if (m_rise) m_ovr <= 1'b1;
                if (dout_ready) begin
                    if (m_idx == 15) begin
                        m_active <= 1'b0; m_xfer <= 1'b1;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model, plus stream monitor
    logic        run_cmp = 1'b0;
    int          xfer_cnt = 0;
    int          ovr_cnt  = 0;
    logic [15:0] rx_dat[$];
    logic        rx_last[$];

    always @(negedge clk) begin
        if (run_cmp) begin
            logic [15:0] exp_w;
            exp_w = m_active ? m_frame[m_idx*16 +: 16] : 16'h0;
            check("model_cycle",
                  {41'h0, dout_valid, busy, dout_last, xfer_done, overrun, no_inv,
                   (dout_valid ? dataout : 16'h0)},
                  {41'h0, m_active, m_active, (m_active && m_idx == 15), m_xfer, m_ovr, m_noinv,
                   exp_w});
        end
        if (dout_valid && dout_ready) begin
            rx_dat.push_back(dataout);
            rx_last.push_back(dout_last);
        end
        xfer_cnt += int'(xfer_done);
        ovr_cnt  += int'(overrun);
    end

    // ---------------- stimulus helpers (inputs change 1 time unit after posedge)
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string name, input int xb, input int budget);
        int i = 0;
        while (xfer_cnt == xb && i < budget) begin step(1); i++; end
        check(name, 64'(xfer_cnt - xb), 64'd1);
    endtask

    task automatic check_ramp(input string name, input int base);
        for (int k = 0; k < 16; k++) begin
            check(name, {47'h0, rx_last[base+k], rx_dat[base+k]}, {47'h0, (k == 15), 16'(k)});
        end
    endtask

    logic [255:0] u_ramp;
    int b, xb, ob;

    initial begin
        for (int k = 0; k < 16; k++) u_ramp[k*16 +: 16] = 16'(k);
        rst_n = 1'b0; u = '0; minv_flag = 1'b0; minv_rdy = 1'b0; dout_ready = 1'b0;
        step(2);
        check("reset_outputs",
              {dataout, dout_valid, dout_last, no_inv, busy, xfer_done, overrun}, 64'h0);
        rst_n = 1'b1;
        run_cmp = 1'b1;
        step(2);

        // basic frame
        u = u_ramp; minv_flag = 1'b0; dout_ready = 1'b1; minv_rdy = 1'b1;
        b = rx_dat.size(); xb = xfer_cnt;
        step(1);
        check("first_word_latency", {dout_valid, dataout}, {1'b1, 16'h0000});
        wait_done("basic_done", xb, 40);
        check_ramp("basic_word", b);
        check("basic_no_inv", {63'h0, no_inv}, 64'h0);
        minv_rdy = 1'b0;
        step(2);

        // backpressure 1,0,0,1,...
        b = rx_dat.size(); xb = xfer_cnt;
        minv_rdy = 1'b1;
        for (int c = 0; c < 200 && xfer_cnt == xb; c++) begin
            dout_ready = (c % 4 == 0) || (c % 4 == 3);
            step(1);
        end
        check("bp_done", 64'(xfer_cnt - xb), 64'd1);
        check("bp_handshakes", 64'(rx_dat.size() - b), 64'd16);
        check_ramp("bp_word", b);
        minv_rdy = 1'b0; dout_ready = 1'b1;
        step(2);

        // no inverse
        u = 256'h5; minv_flag = 1'b1; minv_rdy = 1'b1;
        b = rx_dat.size(); xb = xfer_cnt;
        wait_done("noinv_done", xb, 40);
        check("noinv_word0", {48'h0, rx_dat[b]}, 64'h5);
        for (int k = 1; k < 16; k++) check("noinv_wordk", {48'h0, rx_dat[b+k]}, 64'h0);
        minv_rdy = 1'b0; minv_flag = 1'b0;
        step(3);
        check("noinv_held_idle", {62'h0, no_inv, busy}, 64'h2);

        // overrun: re-raise minv_rdy while word 5 is presented
        u = u_ramp; minv_rdy = 1'b1;
        b = rx_dat.size(); xb = xfer_cnt; ob = ovr_cnt;
        step(1);
        step(5);
        check("ovr_at_word5", {48'h0, dataout}, 64'h5);
        minv_rdy = 1'b0; step(1);
        minv_rdy = 1'b1; u = '0;
        wait_done("ovr_done", xb, 40);
        check("ovr_pulses", 64'(ovr_cnt - ob), 64'd1);
        check_ramp("ovr_word", b);
        step(3);
        check("ovr_no_recapture", {63'h0, busy}, 64'h0);
        minv_rdy = 1'b0;
        step(2);

        // level flag held for 40 cycles -> exactly one frame
        u = u_ramp; minv_rdy = 1'b1; xb = xfer_cnt;
        step(40);
        check("level_one_frame", 64'(xfer_cnt - xb), 64'd1);
        check("level_idle", {63'h0, busy}, 64'h0);
        minv_rdy = 1'b0;
        step(2);

        // reset mid-frame at word 7, minv_rdy left high
        minv_flag = 1'b1; minv_rdy = 1'b1; xb = xfer_cnt;
        step(1);
        step(7);
        check("rst_at_word7", {48'h0, dataout}, 64'h7);
        rst_n = 1'b0;
        #1;
        check("rst_outputs_zero",
              {dataout, dout_valid, dout_last, no_inv, busy, xfer_done, overrun}, 64'h0);
        step(2);
        check("rst_no_xfer", 64'(xfer_cnt - xb), 64'd0);
        rst_n = 1'b1;
        b = rx_dat.size();
        step(1);
        check("restart_first_clock", {47'h0, dout_valid, dataout}, {47'h0, 1'b1, 16'h0});
        wait_done("restart_done", xb, 40);
        check_ramp("restart_word", b);
        minv_rdy = 1'b0; minv_flag = 1'b0;
        step(2);

        // randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) minv_rdy = ~minv_rdy;
            dout_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int w = 0; w < 8; w++) u[w*32 +: 32] = $urandom;
                minv_flag = $urandom_range(0, 1) == 1;
            end
            step(1);
        end
        minv_rdy = 1'b0; dout_ready = 1'b1;
        step(20);
        check("random_drained", {63'h0, busy}, 64'h0);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
